// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among NREQ byte producers.
// Sends an optional channel-tag byte then the data byte, with a done-pulse watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter bit          TAG_EN  = 1'b1,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Enable,
    input  logic [NREQ-1:0]     Req,
    input  logic [8*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]     ReqAck,
    output logic [7:0]          TxData,
    output logic                TxEn,
    input  logic                TxDone,
    output logic                Busy,
    output logic                Err,
    output logic [2:0]          ErrId
);

    localparam int unsigned IDW = 3;
    localparam int unsigned CW  = 24;
    localparam int unsigned BW  = 8;
    localparam logic [BW-1:0] TAG_BASE = 8'hA0;

    typedef enum logic [1:0] {IDLE, WAIT_TAG, WAIT_DATA} state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  last, last_n;
    logic [IDW-1:0]  id_q, id_n;
    logic [BW-1:0]   data_q, data_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   tx_data_n;
    logic            tx_en_n;
    logic [NREQ-1:0] ack_n;
    logic            busy_n;
    logic            err_n;
    logic [IDW-1:0]  err_id_n;

    logic [IDW-1:0]  win;
    logic            win_vld;
    logic [BW-1:0]   win_byte;
    logic [NREQ-1:0] win_ack;
    logic [3:0]      idx;

    // Rotating search: first requester at or after last+1, modulo NREQ
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        win_byte = '0;
        win_ack  = '0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 4'(last) + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!win_vld && idx == 4'(i) && Req[i]) begin
                    win        = IDW'(i);
                    win_vld    = 1'b1;
                    win_byte   = ReqData[8*i +: 8];
                    win_ack[i] = 1'b1;
                end
            end
        end
    end

    // Next-state, watchdog and output decode
    always_comb begin
        state_n   = state;
        last_n    = last;
        id_n      = id_q;
        data_n    = data_q;
        cnt_n     = cnt;
        tx_data_n = TxData;
        tx_en_n   = 1'b0;
        ack_n     = '0;
        err_n     = 1'b0;
        err_id_n  = ErrId;

        if (state == IDLE) begin
            if (Enable && win_vld) begin
                ack_n     = win_ack;
                tx_en_n   = 1'b1;
                id_n      = win;
                data_n    = win_byte;
                tx_data_n = TAG_EN ? (TAG_BASE | BW'(win)) : win_byte;
                state_n   = TAG_EN ? WAIT_TAG : WAIT_DATA;
                cnt_n     = '0;
            end
        end else if (TxDone) begin
            // A done pulse takes priority over a coincident timeout
            if (state == WAIT_TAG) begin
                tx_en_n   = 1'b1;
                tx_data_n = data_q;
                state_n   = WAIT_DATA;
                cnt_n     = '0;
            end else begin
                last_n  = id_q;
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else if (cnt == TIMEOUT - 24'd1) begin
            err_n    = 1'b1;
            err_id_n = id_q;
            last_n   = id_q;
            state_n  = IDLE;
            cnt_n    = '0;
        end else begin
            cnt_n = cnt + CW'(1);
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            last   <= IDW'(NREQ - 1);
            id_q   <= '0;
            data_q <= '0;
            cnt    <= '0;
            TxData <= '0;
            TxEn   <= 1'b0;
            ReqAck <= '0;
            Busy   <= 1'b0;
            Err    <= 1'b0;
            ErrId  <= '0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            id_q   <= id_n;
            data_q <= data_n;
            cnt    <= cnt_n;
            TxData <= tx_data_n;
            TxEn   <= tx_en_n;
            ReqAck <= ack_n;
            Busy   <= busy_n;
            Err    <= err_n;
            ErrId  <= err_id_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a tagged (TIMEOUT=32) and an untagged (TIMEOUT=16) instance
// compared every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic             en    [ND];
    logic [NREQ-1:0]  req   [ND];
    logic [8*NREQ-1:0] rdata [ND];
    logic             done  [ND];
    logic [NREQ-1:0]  ack   [ND];
    logic [7:0]       txd   [ND];
    logic             txen  [ND];
    logic             busy  [ND];
    logic             err   [ND];
    logic [2:0]       errid [ND];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .TAG_EN(1'b1), .TIMEOUT(24'd32)) u_tag (
        .Clk(clk), .Rst_n(rst_n), .Enable(en[0]), .Req(req[0]), .ReqData(rdata[0]),
        .ReqAck(ack[0]), .TxData(txd[0]), .TxEn(txen[0]), .TxDone(done[0]),
        .Busy(busy[0]), .Err(err[0]), .ErrId(errid[0]));

    uart_tx_arbiter #(.NREQ(NREQ), .TAG_EN(1'b0), .TIMEOUT(24'd16)) u_raw (
        .Clk(clk), .Rst_n(rst_n), .Enable(en[1]), .Req(req[1]), .ReqData(rdata[1]),
        .ReqAck(ack[1]), .TxData(txd[1]), .TxEn(txen[1]), .TxDone(done[1]),
        .Busy(busy[1]), .Err(err[1]), .ErrId(errid[1]));

    // Reference model: ph 0 = no transfer, 1 = tag byte on the wire, 2 = data byte on the wire
    int              ph [ND], wt [ND], mlast [ND], mid [ND];
    logic [7:0]      mdata [ND];
    logic [NREQ-1:0] x_ack [ND];
    logic [7:0]      x_txd [ND];
    logic            x_txen [ND], x_busy [ND], x_err [ND];
    logic [2:0]      x_errid [ND];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    bit rnd    = 1'b0;
    bit hold   = 1'b0;
    int dly [ND];
    int cd  [ND];

    logic [7:0] sent  [ND][$];
    int         gid   [ND][$];
    int         txc   [ND][$];
    int         errc  [ND][$];
    int         eids  [ND][$];

    function automatic int tmo(input int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic bit tg(input int d);
        return d == 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset(input int d);
        ph[d] = 0; wt[d] = 0; mlast[d] = NREQ - 1; mid[d] = 0; mdata[d] = '0;
        x_ack[d] = '0; x_txd[d] = '0; x_txen[d] = 1'b0; x_busy[d] = 1'b0;
        x_err[d] = 1'b0; x_errid[d] = '0;
    endtask

    task automatic model_step(input int d);
        int w;
        x_ack[d]  = '0;
        x_txen[d] = 1'b0;
        x_err[d]  = 1'b0;
        if (ph[d] == 0) begin
            if (en[d] && req[d] != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && req[d][(mlast[d] + k) % NREQ]) w = (mlast[d] + k) % NREQ;
                mid[d]    = w;
                mdata[d]  = rdata[d][8*w +: 8];
                x_ack[d][w] = 1'b1;
                x_txen[d] = 1'b1;
                x_txd[d]  = tg(d) ? (8'hA0 | 8'(w)) : mdata[d];
                ph[d]     = tg(d) ? 1 : 2;
                wt[d]     = 0;
            end
        end else if (done[d]) begin
            if (ph[d] == 1) begin
                x_txen[d] = 1'b1; x_txd[d] = mdata[d]; ph[d] = 2; wt[d] = 0;
            end else begin
                mlast[d] = mid[d]; ph[d] = 0;
            end
        end else if (wt[d] == tmo(d) - 1) begin
            x_err[d] = 1'b1; x_errid[d] = 3'(mid[d]); mlast[d] = mid[d]; ph[d] = 0;
        end else begin
            wt[d]++;
        end
        x_busy[d] = (ph[d] != 0);
    endtask

    task automatic check_out(input int d);
        chk($sformatf("d%0d ack", d),    32'(ack[d]),   32'(x_ack[d]));
        chk($sformatf("d%0d txdata", d), 32'(txd[d]),   32'(x_txd[d]));
        chk($sformatf("d%0d txen", d),   32'(txen[d]),  32'(x_txen[d]));
        chk($sformatf("d%0d busy", d),   32'(busy[d]),  32'(x_busy[d]));
        chk($sformatf("d%0d err", d),    32'(err[d]),   32'(x_err[d]));
        chk($sformatf("d%0d errid", d),  32'(errid[d]), 32'(x_errid[d]));
    endtask

    task automatic log_out(input int d);
        if (txen[d]) begin sent[d].push_back(txd[d]); txc[d].push_back(cyc); end
        for (int i = 0; i < NREQ; i++) if (ack[d][i]) gid[d].push_back(i);
        if (err[d]) begin errc[d].push_back(cyc); eids[d].push_back(int'(errid[d])); end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < ND; d++) begin
            sent[d].delete(); gid[d].delete(); txc[d].delete(); errc[d].delete(); eids[d].delete();
        end
    endtask

    // TX core model and requester behaviour for the next edge
    task automatic stim(input int d);
        int r;
        if (txen[d]) begin
            if (rnd) begin
                r = int'($urandom_range(9, 0));
                cd[d] = (r <= 6) ? 1 + int'($urandom_range(5, 0)) : (r == 7) ? 16 : (r == 8) ? 0 : 20;
            end else begin
                cd[d] = dly[d];
            end
        end
        done[d] = 1'b0;
        if (cd[d] > 0) begin
            cd[d]--;
            if (cd[d] == 0) done[d] = 1'b1;
        end else if (rnd && $urandom_range(39, 0) == 0) begin
            done[d] = 1'b1;
        end
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[d][i]) begin
                    if (ack[d][i]) begin
                        if ($urandom_range(1, 0) == 0) req[d][i] = 1'b0;
                        rdata[d][8*i +: 8] = 8'($urandom);
                    end else if ($urandom_range(59, 0) == 0) begin
                        req[d][i] = 1'b0;
                    end
                end else if ($urandom_range(5, 0) == 0) begin
                    rdata[d][8*i +: 8] = 8'($urandom);
                    req[d][i] = 1'b1;
                end
            end
            if ($urandom_range(79, 0) == 0) en[d] = ~en[d];
        end else if (!hold) begin
            req[d] = req[d] & ~ack[d];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) model_reset(d); else model_step(d);
            check_out(d);
            log_out(d);
            stim(d);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin cd[d] = 0; done[d] = 1'b0; end
        #1;
        for (int d = 0; d < ND; d++) begin model_reset(d); check_out(d); end
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            en[d] = 1'b1; req[d] = '0; rdata[d] = '0; done[d] = 1'b0; dly[d] = 3; cd[d] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Single requester, tag then data on the tagged instance
        clear_logs();
        dly[0] = 20; dly[1] = 5;
        for (int d = 0; d < ND; d++) begin req[d] = 4'b0100; rdata[d][23:16] = 8'h5A; end
        cycle();
        chk("t1 ack", 32'(ack[0]), 32'h4);
        repeat (59) cycle();
        chk("t1 nbytes tag", 32'(sent[0].size()), 32'd2);
        chk("t1 tag byte", 32'(sent[0][0]), 32'hA2);
        chk("t1 data byte", 32'(sent[0][1]), 32'h5A);
        chk("t1 raw byte", 32'(sent[1][0]), 32'h5A);
        chk("t1 idle", 32'(busy[0]), 32'd0);

        // All four requesting continuously
        do_reset();
        clear_logs();
        hold = 1'b1; dly[0] = 3; dly[1] = 3;
        for (int d = 0; d < ND; d++) begin rdata[d] = 32'h13121110; req[d] = 4'b1111; end
        repeat (60) cycle();
        for (int d = 0; d < ND; d++) req[d] = '0;
        repeat (30) cycle();
        begin
            logic [7:0] exp_seq [5];
            exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("t2 raw byte%0d", j), 32'(sent[1][j]), 32'(exp_seq[j]));
                chk($sformatf("t2 tag data%0d", j), 32'(sent[0][2*j+1]), 32'(exp_seq[j]));
            end
            chk("t2 tag a1", 32'(sent[0][2]), 32'hA1);
            chk("t2 acks per byte", 32'(gid[1].size()), 32'(sent[1].size()));
        end

        // Fairness with last = 0
        do_reset();
        hold = 1'b0;
        for (int d = 0; d < ND; d++) req[d] = 4'b0001;
        repeat (20) cycle();
        clear_logs();
        hold = 1'b1;
        for (int d = 0; d < ND; d++) req[d] = 4'b1001;
        repeat (40) cycle();
        for (int d = 0; d < ND; d++) req[d] = '0;
        repeat (20) cycle();
        for (int d = 0; d < ND; d++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("t3 d%0d grant%0d", d, j), 32'(gid[d][j]), (j % 2 == 0) ? 32'd3 : 32'd0);

        // Watchdog abort with no done pulse
        do_reset();
        clear_logs();
        hold = 1'b0; dly[0] = 0; dly[1] = 0;
        for (int d = 0; d < ND; d++) req[d] = 4'b0110;
        repeat (60) cycle();
        chk("t4 raw err delay", 32'(errc[1][0] - txc[1][0]), 32'd16);
        chk("t4 raw errid", 32'(eids[1][0]), 32'd1);
        chk("t4 raw grant0", 32'(gid[1][0]), 32'd1);
        chk("t4 raw grant1", 32'(gid[1][1]), 32'd2);
        chk("t4 tag err delay", 32'(errc[0][0] - txc[0][0]), 32'd32);

        // Done pulse coinciding with the timeout
        do_reset();
        clear_logs();
        dly[0] = 32; dly[1] = 16;
        for (int d = 0; d < ND; d++) begin req[d] = 4'b0001; rdata[d][7:0] = 8'hC3; end
        repeat (80) cycle();
        chk("t5 raw no err", 32'(errc[1].size()), 32'd0);
        chk("t5 tag no err", 32'(errc[0].size()), 32'd0);
        chk("t5 raw bytes", 32'(sent[1].size()), 32'd1);
        chk("t5 tag bytes", 32'(sent[0].size()), 32'd2);

        // Reset while waiting for the data byte, then a late done pulse
        do_reset();
        clear_logs();
        dly[0] = 0; dly[1] = 0;
        for (int d = 0; d < ND; d++) req[d] = 4'b0001;
        repeat (3) cycle();
        do_reset();
        for (int d = 0; d < ND; d++) done[d] = 1'b1;
        repeat (6) cycle();
        chk("t6 raw grants", 32'(gid[1].size()), 32'd1);
        chk("t6 raw no err", 32'(errc[1].size()), 32'd0);
        chk("t6 raw idle", 32'(busy[1]), 32'd0);

        // Enable low blocks new grants
        clear_logs();
        hold = 1'b1; dly[0] = 3; dly[1] = 3;
        for (int d = 0; d < ND; d++) begin en[d] = 1'b0; req[d] = 4'b1111; end
        repeat (12) cycle();
        chk("t7 no ack", 32'(gid[1].size() + gid[0].size()), 32'd0);
        chk("t7 no txen", 32'(sent[1].size() + sent[0].size()), 32'd0);
        for (int d = 0; d < ND; d++) en[d] = 1'b1;
        repeat (20) cycle();
        chk("t7 resumed", 32'(gid[1].size() > 0), 32'd1);
        for (int d = 0; d < ND; d++) req[d] = '0;
        repeat (20) cycle();

        // Randomized traffic against the model
        hold = 1'b0;
        rnd  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(499, 0) == 0) do_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single RS232 transmitter among up to 8 byte-producing requesters. It captures one byte from the winning requester and sends an optional channel-tag byte followed by the data byte. Each byte is issued as a one-cycle start pulse to the transmitter, and the arbiter waits for the transmitter's done pulse before continuing. It sits between client logic and the TX core, in the same divided-clock domain as the baud-rate generator, and includes a watchdog that recovers from a missing done pulse.

## Interface
- NREQ, 4: number of requesters, legal range 2..8.
- TAG_EN, 1: 1 sends the tag byte 8'hA0 | id before each data byte; 0 sends the data byte only.
- TIMEOUT, 24'd1000000: maximum number of cycles spent in a wait state before abort; must be nonzero.
- Clk  in  1  system clock (divided UART clock).
- Rst_n  in  1  asynchronous active-low reset.
- Enable  in  1  arbitration enable; while low, no new grant is made, but a transfer already in flight completes.
- Req  in  NREQ  per-requester request level.
- ReqData  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
- ReqAck  out  NREQ  one-cycle, one-hot pulse meaning the byte was captured.
- TxData  out  8  byte presented to the TX core.
- TxEn  out  1  one-cycle start pulse to the TX core.
- TxDone  in  1  one-cycle pulse from the TX core at the end of the stop bit.
- Busy  out  1  high whenever the state is not IDLE.
- Err  out  1  one-cycle pulse on watchdog abort.
- ErrId  out  3  id of the aborted transfer; holds its value until the next abort.

## Operation
- States: IDLE, WAIT_TAG, WAIT_DATA.
- IDLE, with Enable=1 and any Req bit set:
  - Select the winner: the first set Req bit searching upward from last+1, wrapping modulo NREQ.
  - On the next edge, latch ReqData[winner] into data_q and winner into id_q.
  - Pulse ReqAck[winner].
  - Pulse TxEn with TxData = TAG_EN ? (8'hA0|winner) : ReqData[winner].
  - Go to WAIT_TAG if TAG_EN, else WAIT_DATA.
  - Clear the watchdog counter.
- WAIT_TAG, on TxDone: pulse TxEn with TxData = data_q, go to WAIT_DATA, clear the counter.
- WAIT_DATA, on TxDone: set last = id_q, go to IDLE.
- Watchdog, in either wait state with no TxDone:
  - The counter increments each cycle.
  - When counter = TIMEOUT-1: pulse Err, set ErrId = id_q, set last = id_q, go to IDLE.
  - No retry is attempted.
  - Counter width is 24 bits; it never wraps because the abort fires first.
- TxDone in IDLE is ignored.
- If TxDone and the timeout coincide, TxDone wins and Err is not asserted.
- Requester contract:
  - Hold Req and ReqData stable until ReqAck.
  - Req still high in the cycle after ReqAck counts as a new request.
  - Dropping Req before ack withdraws the request with no side effect.
- Requesters that are not selected are never acked; their data is not sampled.
- Enable falling during a wait state has no effect until the return to IDLE.
- All outputs are registered.
- After a transfer or an abort, TxData keeps its last value and TxEn stays 0.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE, last = NREQ-1 (so requester 0 wins first).
  - TxData = 0, TxEn = 0, ReqAck = 0, Busy = 0, Err = 0, ErrId = 0, data_q = 0, id_q = 0, counter = 0.
- Reset during a transfer aborts it silently: no Err, no ReqAck. A TxDone arriving after reset is ignored.
- Grant latency: Req sampled high in IDLE at edge k gives ReqAck, TxEn and Busy all high in cycle k+1.
- Tag to data: TxDone high in cycle n gives the data-byte TxEn high in cycle n+1.
- Completion: TxDone in WAIT_DATA in cycle n gives IDLE in cycle n+1, and the earliest next grant in cycle n+2. There is a minimum of one IDLE cycle between transfers.
- Abort: Err is high in the cycle immediately after counter = TIMEOUT-1 is sampled, and Busy falls in that same cycle.
- Under persistent requests, each requester is granted at most once per NREQ grants.

## Test plan
- Single requester, TAG_EN=1:
  - Stimulus: Req=4'b0100, ReqData[23:16]=8'h5A, TX model returns TxDone 20 cycles after each TxEn.
  - Required: ReqAck=4'b0100 one cycle later; TxEn pulses with TxData 8'hA2 then 8'h5A; Busy falls the cycle after the second TxDone.
- All four requesting continuously with data 8'h10..8'h13, TAG_EN=0:
  - Required: data bytes in order 10,11,12,13,10 with one ReqAck each.
- Fairness:
  - Stimulus: Req=4'b1001 held, last=0.
  - Required: grants alternate 3,0,3,0.
- Watchdog, TIMEOUT=16:
  - Stimulus: requester 1 granted, no TxDone returned.
  - Required: Err pulse exactly 16 cycles after the TxEn cycle, ErrId=1, Busy=0; the next grant goes to requester 2 if it is requesting.
- Simultaneous TxDone and timeout:
  - Required: no Err; transfer proceeds normally.
- Reset and Enable:
  - Stimulus: assert Rst_n=0 in WAIT_DATA.
  - Required: all outputs return to reset values in the same cycle, no Err; a late TxDone is ignored.
  - Stimulus: Enable=0 with Req=4'b1111.
  - Required: no ReqAck and no TxEn until Enable returns to 1.
